gbuff_drain: RTL and testbench

GBUFF_DRAIN -- requirements
Module: gbuff_drain

---
 rtl/gbuff_drain_pkg.sv | 29 ++
 rtl/gbuff_drain_if.sv | 34 +++
 rtl/gbuff_drain_lane_mux.sv | 22 ++
 rtl/gbuff_drain.sv | 139 +++++++++++++
 tb/tb_gbuff_drain.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/gbuff_drain_pkg.sv
// gbuff_drain_pkg -- shared constants for the output-buffer drain block.
//   Lane geometry (8-bit lanes, five per word), default word width,
//   FSM state encoding and the column-count clamp helper.
//   Optional macro DRAIN_CHECKSUM_EN adds the checksum-byte state.
package gbuff_drain_pkg;
  localparam int LANE_W         = 8;
  localparam int NUM_LANES      = 5;
  localparam int DFLT_WORD_SIZE = LANE_W * NUM_LANES;
  localparam int CNT_W          = 4;  // width of m / n / row counter
  localparam int LANE_IDX_W     = 3;  // enough to count 1..NUM_LANES

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_WAIT = 3'd2,
    S_SEND = 3'd3,
    S_FIN  = 3'd4
`ifdef DRAIN_CHECKSUM_EN
    , S_CSUM = 3'd5
`endif
  } state_e;

  // Lanes per row: 0 still sends one lane, anything above the lane count saturates.
  function automatic logic [LANE_IDX_W-1:0] clamp_lanes(input logic [CNT_W-1:0] n);
    if (n == '0) return LANE_IDX_W'(1);
    if (n > CNT_W'(NUM_LANES)) return LANE_IDX_W'(NUM_LANES);
    return n[LANE_IDX_W-1:0];
  endfunction
endpackage

// File: rtl/gbuff_drain_if.sv
// gbuff_drain_if -- drain control, output-buffer read port and byte stream.
//   done_in/m/n    : engine done level and result geometry (into the drain)
//   rd_en/rd_addr  : buffer read strobe and row address (from the drain)
//   rd_data        : buffer word, valid one cycle after rd_en (into the drain)
//   out_*          : valid/ready byte stream with out_last (from the drain)
//   busy/drain_done: status level and completion pulse (from the drain)
// Modport master is the drain block, slave is its environment.
interface gbuff_drain_if import gbuff_drain_pkg::*; #(
  parameter int WORD_SIZE = DFLT_WORD_SIZE,
  parameter int ADDR_W    = 8
);
  logic                 done_in;
  logic [CNT_W-1:0]     m;
  logic [CNT_W-1:0]     n;
  logic                 rd_en;
  logic [ADDR_W-1:0]    rd_addr;
  logic [WORD_SIZE-1:0] rd_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [LANE_W-1:0]    out_data;
  logic                 out_last;
  logic                 busy;
  logic                 drain_done;

  modport master (
    input  done_in, m, n, rd_data, out_ready,
    output rd_en, rd_addr, out_valid, out_data, out_last, busy, drain_done
  );

  modport slave (
    output done_in, m, n, rd_data, out_ready,
    input  rd_en, rd_addr, out_valid, out_data, out_last, busy, drain_done
  );
endinterface

// File: rtl/gbuff_drain_lane_mux.sv
// drain_lane_mux -- picks one 8-bit lane out of the holding word.
//   i_word : holding register (lane 0 is the most significant byte)
//   i_idx  : lane index 0..NUM_LANES-1
//   o_byte : selected lane (0 for an out-of-range index)
module drain_lane_mux import gbuff_drain_pkg::*; #(
  parameter int WORD_SIZE = DFLT_WORD_SIZE
) (
  input  logic [WORD_SIZE-1:0]  i_word,
  input  logic [LANE_IDX_W-1:0] i_idx,
  output logic [LANE_W-1:0]     o_byte
);
  logic [NUM_LANES-1:0][LANE_W-1:0] w_lanes;

  assign w_lanes = i_word[NUM_LANES*LANE_W-1:0];

  // Index 0 maps to the top lane so bytes leave MSB-first.
  always_comb begin
    o_byte = '0;
    for (int k = 0; k < NUM_LANES; k++)
      if (i_idx == LANE_IDX_W'(k)) o_byte = w_lanes[NUM_LANES-1-k];
  end
endmodule

// File: rtl/gbuff_drain.sv
// gbuff_drain -- drains an m x n result from the output buffer as a byte stream.
//   clk, rst : single clock, asynchronous active-high reset
//   bus      : gbuff_drain_if.master (done/geometry in, buffer read port,
//              byte stream, busy / drain_done status)
// A done_in rising edge seen in IDLE latches m/n and walks the rows:
// READ (strobe row address) -> WAIT (buffer latency) -> SEND (n lanes, MSB first).
// Optional macro DRAIN_CHECKSUM_EN appends a mod-256 sum byte that carries out_last.
module gbuff_drain import gbuff_drain_pkg::*; #(
  parameter int WORD_SIZE = DFLT_WORD_SIZE,
  parameter int ADDR_W    = 8
) (
  input logic            clk,
  input logic            rst,
  gbuff_drain_if.master  bus
);
`ifdef DRAIN_CHECKSUM_EN
  localparam state_e S_TAIL = S_CSUM;
`else
  localparam state_e S_TAIL = S_FIN;
`endif

  state_e                r_state, w_next;
  logic                  r_done_q;
  logic                  r_armed;   // blocks a start on the first cycle out of reset
  logic [CNT_W-1:0]      r_m, r_row;
  logic [LANE_IDX_W-1:0] r_n, r_lane;
  logic [WORD_SIZE-1:0]  r_hold;
  logic [LANE_W-1:0]     w_lane_byte;
  logic                  w_start, w_xfer, w_last_lane, w_last_row;
`ifdef DRAIN_CHECKSUM_EN
  logic [LANE_W-1:0]     r_sum;
`endif

  assign w_start     = (r_state == S_IDLE) && r_armed && bus.done_in && !r_done_q;
  assign w_xfer      = bus.out_valid && bus.out_ready;
  assign w_last_lane = (r_lane == r_n - LANE_IDX_W'(1));
  assign w_last_row  = (r_row + CNT_W'(1) == r_m);

  drain_lane_mux #(.WORD_SIZE(WORD_SIZE)) u_mux (
    .i_word (r_hold),
    .i_idx  (r_lane),
    .o_byte (w_lane_byte)
  );

  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;

  // next state
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_start) w_next = (bus.m == '0) ? S_TAIL : S_READ;
      S_READ: w_next = S_WAIT;
      S_WAIT: w_next = S_SEND;
      S_SEND: if (w_xfer && w_last_lane) w_next = w_last_row ? S_TAIL : S_READ;
`ifdef DRAIN_CHECKSUM_EN
      S_CSUM: if (w_xfer) w_next = S_FIN;
`endif
      S_FIN:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // outputs
  always_comb begin
    bus.rd_en      = 1'b0;
    bus.rd_addr    = '0;
    bus.out_valid  = 1'b0;
    bus.out_data   = '0;
    bus.out_last   = 1'b0;
    bus.busy       = (r_state != S_IDLE);
    bus.drain_done = 1'b0;
    unique case (r_state)
      S_READ: begin
        bus.rd_en   = 1'b1;
        bus.rd_addr = ADDR_W'(r_row);
      end
      S_SEND: begin
        bus.out_valid = 1'b1;
        bus.out_data  = w_lane_byte;
`ifndef DRAIN_CHECKSUM_EN
        bus.out_last  = w_last_lane && w_last_row;
`endif
      end
`ifdef DRAIN_CHECKSUM_EN
      S_CSUM: begin
        bus.out_valid = 1'b1;
        bus.out_data  = r_sum;
        bus.out_last  = 1'b1;
      end
`endif
      S_FIN:   bus.drain_done = 1'b1;
      default: ;
    endcase
  end

  // datapath: edge register, latched geometry, counters, holding word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done_q <= 1'b0;
      r_armed  <= 1'b0;
      r_m      <= '0;
      r_n      <= '0;
      r_row    <= '0;
      r_lane   <= '0;
      r_hold   <= '0;
`ifdef DRAIN_CHECKSUM_EN
      r_sum    <= '0;
`endif
    end else begin
      r_done_q <= bus.done_in;
      r_armed  <= 1'b1;
      if (w_start) begin
        r_m    <= bus.m;
        r_n    <= clamp_lanes(bus.n);
        r_row  <= '0;
        r_lane <= '0;
`ifdef DRAIN_CHECKSUM_EN
        r_sum  <= '0;
`endif
      end else if (r_state == S_WAIT) begin
        r_hold <= bus.rd_data;
        r_lane <= '0;
      end else if (r_state == S_SEND && w_xfer) begin
`ifdef DRAIN_CHECKSUM_EN
        r_sum <= r_sum + w_lane_byte;
`endif
        if (w_last_lane) begin
          r_lane <= '0;
          r_row  <= r_row + CNT_W'(1);
        end else begin
          r_lane <= r_lane + LANE_IDX_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_gbuff_drain.sv
// tb_gbuff_drain -- directed bench for gbuff_drain.
//   Buffer model answers rd_en one cycle later; a negedge monitor captures
//   transferred bytes, counts strobes/pulses and checks stall stability.
//   Honours DRAIN_CHECKSUM_EN for the expected trailing sum byte.
module tb_gbuff_drain;
  import gbuff_drain_pkg::*;

`ifdef DRAIN_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  logic clk, rst;
  logic tog;
  int   n_chk, n_pass;
  int   n_rd, n_ov, n_dd, n_busy;
  logic [39:0] mem [0:15];
  logic [7:0]  cap_d[$], exp_d[$];
  logic        cap_l[$], exp_l[$];
  logic        stall_q;
  logic [8:0]  stall_v;

  gbuff_drain_if #(.WORD_SIZE(40), .ADDR_W(8)) bus ();

  gbuff_drain #(.WORD_SIZE(40), .ADDR_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // buffer model: one-cycle read latency
  always @(posedge clk)
    if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr[3:0]];

  // ready driver: constant high or toggling every cycle
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.out_ready = tog ? !bus.out_ready : 1'b1;
    end
  end

  // monitor
  always @(negedge clk) begin
    if (bus.rd_en) begin
      chk("rd_addr", 64'(bus.rd_addr), 64'(n_rd));
      n_rd++;
    end
    if (bus.out_valid)  n_ov++;
    if (bus.drain_done) n_dd++;
    if (bus.busy)       n_busy++;
    if (stall_q && bus.out_valid)
      chk("stall_hold", 64'({bus.out_data, bus.out_last}), 64'(stall_v));
    stall_q = bus.out_valid && !bus.out_ready;
    stall_v = {bus.out_data, bus.out_last};
    if (bus.out_valid && bus.out_ready) begin
      cap_d.push_back(bus.out_data);
      cap_l.push_back(bus.out_last);
    end
  end

  task automatic load_5x5();
    mem[0] = 40'h00_00_01_01_01;
    mem[1] = 40'h02_02_01_02_02;
    mem[2] = 40'h01_01_00_01_01;
    mem[3] = 40'h00_01_02_02_02;
    mem[4] = 40'h02_03_02_03_03;
  endtask

  task automatic build_exp(input int mm, input int nn);
    int nc;
    logic [7:0] s, b;
    logic [39:0] w;
    exp_d.delete(); exp_l.delete();
    s  = 8'h00;
    nc = (nn < 1) ? 1 : (nn > 5) ? 5 : nn;
    for (int r = 0; r < mm; r++)
      for (int l = 0; l < nc; l++) begin
        w = mem[r];
        b = w[39-8*l -: 8];
        s = s + b;
        exp_d.push_back(b);
        exp_l.push_back(!CS && r == mm-1 && l == nc-1);
      end
    if (CS) begin
      exp_d.push_back(s);
      exp_l.push_back(1'b1);
    end
  endtask

  task automatic cmp_drain(input string nm);
    chk({nm, "_len"}, 64'(cap_d.size()), 64'(exp_d.size()));
    for (int i = 0; i < exp_d.size() && i < cap_d.size(); i++) begin
      chk($sformatf("%s_data%0d", nm, i), 64'(cap_d[i]), 64'(exp_d[i]));
      chk($sformatf("%s_last%0d", nm, i), 64'(cap_l[i]), 64'(exp_l[i]));
    end
  endtask

  // Raise done_in, wait for drain_done; meanwhile disturb m/n and bounce
  // done_in, none of which may affect the running drain.
  task automatic run_drain(input string nm, input int mm, input int nn,
                           output int first_ov, output int dd_cyc);
    int cyc;
    cap_d.delete(); cap_l.delete();
    n_rd = 0; n_ov = 0; n_dd = 0;
    bus.m = 4'(mm);
    bus.n = 4'(nn);
    @(posedge clk); #1;
    bus.done_in = 1'b1;
    first_ov = -1; dd_cyc = -1; cyc = 0;
    while (dd_cyc < 0 && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.out_valid && first_ov < 0) first_ov = cyc;
      if (bus.drain_done) dd_cyc = cyc;
      if (cyc == 4) begin bus.m = 4'hF; bus.n = 4'hF; bus.done_in = 1'b0; end
      if (cyc == 5) bus.done_in = 1'b1;
    end
    chk({nm, "_dd_seen"}, 64'(dd_cyc >= 0), 64'd1);
    @(posedge clk); #1;
    n_busy = 0;
    repeat (6) @(posedge clk);
    #1;
    chk({nm, "_no_restart"}, 64'(n_busy), 64'd0);
    chk({nm, "_dd_pulses"}, 64'(n_dd), 64'd1);
    chk({nm, "_rd_count"}, 64'(n_rd), 64'(mm));
    bus.done_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int fo, dd, cyc;
    n_chk = 0; n_pass = 0;
    n_rd = 0; n_ov = 0; n_dd = 0; n_busy = 0;
    stall_q = 1'b0; stall_v = '0;
    tog = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    rst = 1'b1;
    bus.done_in = 1'b1;
    bus.m = 4'd5;
    bus.n = 4'd5;

    // reset state, done_in already high
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",  64'(bus.busy), 64'd0);
    chk("rst_rd_en", 64'(bus.rd_en), 64'd0);
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_done",  64'(bus.drain_done), 64'd0);
    chk("rst_data",  64'(bus.out_data), 64'd0);

    // a level that is already high at release is not an edge
    rst = 1'b0;
    n_busy = 0; n_rd = 0;
    repeat (6) @(posedge clk);
    #1;
    chk("no_start_after_rst", 64'(n_busy), 64'd0);
    bus.done_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 5x5, ready always high
    load_5x5();
    build_exp(5, 5);
    run_drain("t5x5", 5, 5, fo, dd);
    cmp_drain("t5x5");
    chk("t5x5_latency", 64'(fo), 64'd3);

    // 5x5, ready toggling
    tog = 1'b1;
    run_drain("tstall", 5, 5, fo, dd);
    tog = 1'b0;
    cmp_drain("tstall");

    // 2 rows, partial, clamped and zero column counts
    mem[0] = 40'h0A_0B_0C_0D_0E;
    mem[1] = 40'h11_12_13_14_15;
    build_exp(2, 3);
    run_drain("t2x3", 2, 3, fo, dd);
    cmp_drain("t2x3");
    chk("t2x3_latency", 64'(fo), 64'd3);
    build_exp(2, 7);
    run_drain("t2x7", 2, 7, fo, dd);
    cmp_drain("t2x7");
    build_exp(2, 0);
    run_drain("t2x0", 2, 0, fo, dd);
    cmp_drain("t2x0");

    // m = 0: straight to completion
    build_exp(0, 5);
    run_drain("tm0", 0, 5, fo, dd);
    cmp_drain("tm0");
    chk("tm0_valid_cycles", 64'(n_ov), CS ? 64'd1 : 64'd0);
    chk("tm0_dd_latency", 64'(dd >= 1 && dd <= 3), 64'd1);

    // reset in the middle of row 2, then restart from row 0
    load_5x5();
    cap_d.delete(); cap_l.delete();
    n_rd = 0;
    bus.m = 4'd5;
    bus.n = 4'd5;
    @(posedge clk); #1;
    bus.done_in = 1'b1;
    cyc = 0;
    while (cap_d.size() < 11 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("mid_bytes",  64'(cap_d.size()), 64'd11);
    chk("mid_busy",   64'(bus.busy), 64'd1);
    chk("mid_valid",  64'(bus.out_valid), 64'd1);
    rst = 1'b1;
    bus.done_in = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_busy",  64'(bus.busy), 64'd0);
    chk("mid_rst_data",  64'(bus.out_data), 64'd0);
    chk("mid_rst_last",  64'(bus.out_last), 64'd0);
    chk("mid_rst_rd_en", 64'(bus.rd_en), 64'd0);
    chk("mid_rst_addr",  64'(bus.rd_addr), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    build_exp(5, 5);
    run_drain("trestart", 5, 5, fo, dd);
    cmp_drain("trestart");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
